// File: rtl/csr_file_wb_if.sv
// EX-stage CSR request/response bundle between the ID-EX pipeline and csr_file_wb.
interface csr_file_wb_if;
  logic [11:0] CSR_addr_EX;
  logic [31:0] CSR_zimm_EX;
  logic        CSR_zimm_or_reg_EX;
  logic        CSR_write_en_EX;
  logic [1:0]  CSR_op_EX;
  logic [31:0] rs1_data_EX;
  logic [31:0] CSR_data_EX;

  modport master (
    output CSR_addr_EX,
    output CSR_zimm_EX,
    output CSR_zimm_or_reg_EX,
    output CSR_write_en_EX,
    output CSR_op_EX,
    output rs1_data_EX,
    input  CSR_data_EX
  );

  modport slave (
    input  CSR_addr_EX,
    input  CSR_zimm_EX,
    input  CSR_zimm_or_reg_EX,
    input  CSR_write_en_EX,
    input  CSR_op_EX,
    input  rs1_data_EX,
    output CSR_data_EX
  );
endinterface

// File: rtl/csr_file_wb.sv
// CSR execute/commit unit: EX read-modify-write with forwarding, private MEM/WB write pipeline,
// commit at end of WB. Define CSR_COUNTERS_EN to add the mcycle/minstret 64-bit counters.
module csr_file_wb (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubbleM,
  input  logic         flushM,
  input  logic         bubbleW,
  input  logic         flushW,
  input  logic         instr_retire_W,
  csr_file_wb_if.slave ex
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  logic [31:0] csr_q [8];

  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [11:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;

  logic [31:0] src;
  logic [31:0] file_rd;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        ex_impl;
  logic        ex_we;
  logic        ex_hit;
  logic [2:0]  ex_idx;
  logic        wb_hit;
  logic [2:0]  wb_idx;
  logic        commit;

  // Maps a plain CSR address to {implemented, storage index}.
  function automatic logic [3:0] slot_of(input logic [11:0] addr);
    logic [3:0] s;
    case (addr)
      ADDR_MSTATUS:  s = 4'b1000;
      ADDR_MIE:      s = 4'b1001;
      ADDR_MTVEC:    s = 4'b1010;
      ADDR_MSCRATCH: s = 4'b1011;
      ADDR_MEPC:     s = 4'b1100;
      ADDR_MCAUSE:   s = 4'b1101;
      ADDR_MTVAL:    s = 4'b1110;
      ADDR_MIP:      s = 4'b1111;
      default:       s = 4'b0000;
    endcase
    return s;
  endfunction

  assign {ex_hit, ex_idx} = slot_of(ex.CSR_addr_EX);
  assign {wb_hit, wb_idx} = slot_of(wb_addr);
  assign commit = wb_we && !bubbleW;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // A committed write to either half replaces that cycle's increment of the whole counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (commit && wb_addr == ADDR_MCYCLE)
        mcycle_q[31:0] <= wb_wdata;
      else if (commit && wb_addr == ADDR_MCYCLEH)
        mcycle_q[63:32] <= wb_wdata;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (commit && wb_addr == ADDR_MINSTRET)
        minstret_q[31:0] <= wb_wdata;
      else if (commit && wb_addr == ADDR_MINSTRETH)
        minstret_q[63:32] <= wb_wdata;
      else if (instr_retire_W)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire_W;
`endif

  always_comb begin
    src     = ex.CSR_zimm_or_reg_EX ? ex.CSR_zimm_EX : ex.rs1_data_EX;
    ex_impl = ex_hit;
    file_rd = ex_hit ? csr_q[ex_idx] : 32'h0;
`ifdef CSR_COUNTERS_EN
    case (ex.CSR_addr_EX)
      ADDR_MCYCLE:    begin ex_impl = 1'b1; file_rd = mcycle_q[31:0];    end
      ADDR_MCYCLEH:   begin ex_impl = 1'b1; file_rd = mcycle_q[63:32];   end
      ADDR_MINSTRET:  begin ex_impl = 1'b1; file_rd = minstret_q[31:0];  end
      ADDR_MINSTRETH: begin ex_impl = 1'b1; file_rd = minstret_q[63:32]; end
      default: ;
    endcase
`endif
    // Youngest pending write wins: MEM before WB before the architectural file.
    if (mem_we && mem_addr == ex.CSR_addr_EX)
      old_val = mem_wdata;
    else if (wb_we && wb_addr == ex.CSR_addr_EX)
      old_val = wb_wdata;
    else
      old_val = file_rd;

    case (ex.CSR_op_EX)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
    if (ex.CSR_addr_EX == ADDR_MTVEC)
      new_val[1:0] = 2'b00;

    ex_we = ex.CSR_write_en_EX && (ex.CSR_op_EX != OP_NONE) && ex_impl;
  end

  assign ex.CSR_data_EX = old_val;

  // A bubble holds its stage even if a flush is requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 12'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      wb_addr   <= 12'h0;
      wb_wdata  <= 32'h0;
      wb_we     <= 1'b0;
    end else begin
      if (!bubbleM) begin
        mem_addr  <= ex.CSR_addr_EX;
        mem_wdata <= new_val;
        mem_we    <= flushM ? 1'b0 : ex_we;
      end
      if (!bubbleW) begin
        wb_addr  <= mem_addr;
        wb_wdata <= mem_wdata;
        wb_we    <= flushW ? 1'b0 : mem_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++)
        csr_q[i] <= 32'h0;
    end else if (commit && wb_hit) begin
      csr_q[wb_idx] <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_csr_file_wb.sv
// Self-checking bench for csr_file_wb: an address-indexed CSR model with in-flight write list,
// compared against CSR_data_EX every cycle, plus hand-computed literal expectations.
module tb_csr_file_wb;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  logic bubbleM;
  logic flushM;
  logic bubbleW;
  logic flushW;
  logic instr_retire_W;

  csr_file_wb_if bus ();

  csr_file_wb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bubbleM        (bubbleM),
    .flushM         (flushM),
    .bubbleW        (bubbleW),
    .flushW         (flushW),
    .instr_retire_W (instr_retire_W),
    .ex             (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [11:0] addr;
    logic [31:0] data;
  } slot_t;

  slot_t       pend_mem;
  slot_t       pend_wb;
  logic [31:0] mfile [0:4095];
`ifdef CSR_COUNTERS_EN
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
`endif

  int          checks = 0;
  int          errors = 0;
  logic        pin_valid = 1'b0;
  logic [31:0] pin_value = 32'h0;
  string       pin_name = "";

  function automatic logic is_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340,
      12'h341, 12'h342, 12'h343, 12'h344: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] file_read(input logic [11:0] a);
`ifdef CSR_COUNTERS_EN
    case (a)
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: ;
    endcase
`endif
    return is_impl(a) ? mfile[a] : 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (pend_mem.valid && pend_mem.addr == a) return pend_mem.data;
    if (pend_wb.valid && pend_wb.addr == a) return pend_wb.data;
    return file_read(a);
  endfunction

  // Model: architectural state advances once per rising edge.
  always @(posedge clk or negedge rst_n) begin
    slot_t       ex_s;
    logic [31:0] old_v;
    logic [31:0] src_v;
    logic [31:0] nv;
    logic        cyc_wr;
    logic        ins_wr;
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mfile[i] = 32'h0;
      pend_mem = '0;
      pend_wb  = '0;
`ifdef CSR_COUNTERS_EN
      m_cycle   = 64'h0;
      m_instret = 64'h0;
`endif
    end else begin
      old_v = model_read(bus.CSR_addr_EX);
      src_v = bus.CSR_zimm_or_reg_EX ? bus.CSR_zimm_EX : bus.rs1_data_EX;
      case (bus.CSR_op_EX)
        OP_RW:   nv = src_v;
        OP_RS:   nv = old_v | src_v;
        OP_RC:   nv = old_v & ~src_v;
        default: nv = old_v;
      endcase
      if (bus.CSR_addr_EX == 12'h305) nv = nv & 32'hFFFF_FFFC;
      ex_s.valid = bus.CSR_write_en_EX && bus.CSR_op_EX != OP_NONE && is_impl(bus.CSR_addr_EX);
      ex_s.addr  = bus.CSR_addr_EX;
      ex_s.data  = nv;

      cyc_wr = 1'b0;
      ins_wr = 1'b0;
      if (pend_wb.valid && !bubbleW) begin
        mfile[pend_wb.addr] = pend_wb.data;
`ifdef CSR_COUNTERS_EN
        case (pend_wb.addr)
          12'hB00: begin m_cycle[31:0]    = pend_wb.data; cyc_wr = 1'b1; end
          12'hB80: begin m_cycle[63:32]   = pend_wb.data; cyc_wr = 1'b1; end
          12'hB02: begin m_instret[31:0]  = pend_wb.data; ins_wr = 1'b1; end
          12'hB82: begin m_instret[63:32] = pend_wb.data; ins_wr = 1'b1; end
          default: ;
        endcase
`endif
      end
`ifdef CSR_COUNTERS_EN
      if (!cyc_wr) m_cycle = m_cycle + 64'd1;
      if (!ins_wr && instr_retire_W) m_instret = m_instret + 64'd1;
`else
      if (cyc_wr || ins_wr) nv = 32'h0;
`endif
      if (!bubbleW) begin
        pend_wb = pend_mem;
        if (flushW) pend_wb.valid = 1'b0;
      end
      if (!bubbleM) begin
        pend_mem = ex_s;
        if (flushM) pend_mem.valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_v;
    exp_v = model_read(bus.CSR_addr_EX);
    checks = checks + 1;
    if (bus.CSR_data_EX !== exp_v) begin
      errors = errors + 1;
      $display("[TB] FAIL csr_data addr=%h got=%h expected=%h t=%0t",
               bus.CSR_addr_EX, bus.CSR_data_EX, exp_v, $time);
    end
    if (pin_valid) begin
      checks = checks + 1;
      if (exp_v !== pin_value) begin
        errors = errors + 1;
        $display("[TB] FAIL model_%s got=%h expected=%h", pin_name, exp_v, pin_value);
      end
      checks = checks + 1;
      if (bus.CSR_data_EX !== pin_value) begin
        errors = errors + 1;
        $display("[TB] FAIL %s got=%h expected=%h", pin_name, bus.CSR_data_EX, pin_value);
      end
    end
  end

  // ctrl = {bubbleM, flushM, bubbleW, flushW, instr_retire_W}
  task automatic apply_stimulus(input logic [11:0] addr, input logic [1:0] op, input logic we,
                                input logic use_zimm, input logic [31:0] src,
                                input logic [4:0] ctrl);
    @(posedge clk);
    #1;
    pin_valid                 = 1'b0;
    bus.CSR_addr_EX           = addr;
    bus.CSR_op_EX             = op;
    bus.CSR_write_en_EX       = we;
    bus.CSR_zimm_or_reg_EX    = use_zimm;
    bus.CSR_zimm_EX           = use_zimm ? src : ~src;
    bus.rs1_data_EX           = use_zimm ? ~src : src;
    {bubbleM, flushM, bubbleW, flushW, instr_retire_W} = ctrl;
  endtask

  task automatic check_output(input string name, input logic [31:0] value);
    pin_name  = name;
    pin_value = value;
    pin_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(12'h000, OP_NONE, 1'b0, 1'b0, 32'h0, 5'b0);
  endtask

  task automatic read_csr(input logic [11:0] addr, input logic [4:0] ctrl);
    apply_stimulus(addr, OP_RS, 1'b0, 1'b0, 32'h0, ctrl);
  endtask

  initial begin
    rst_n = 1'b1;
    {bubbleM, flushM, bubbleW, flushW, instr_retire_W} = 5'b0;
    bus.CSR_addr_EX = 12'h0;
    bus.CSR_op_EX = OP_NONE;
    bus.CSR_write_en_EX = 1'b0;
    bus.CSR_zimm_or_reg_EX = 1'b0;
    bus.CSR_zimm_EX = 32'h0;
    bus.rs1_data_EX = 32'h0;
    #2 rst_n = 1'b0;

    read_csr(12'h300, 5'b0); check_output("rst_mstatus", 32'h0);
    read_csr(12'h305, 5'b0); check_output("rst_mtvec", 32'h0);
    read_csr(12'hB00, 5'b0); check_output("rst_mcycle", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    idle(9);
    read_csr(12'hB00, 5'b0);
`ifdef CSR_COUNTERS_EN
    check_output("mcycle_after_10", 32'd10);
`else
    check_output("mcycle_absent", 32'd0);
`endif

    // Three back-to-back writes to mstatus: EX must see the MEM value.
    apply_stimulus(12'h300, OP_RW, 1'b1, 1'b0, 32'h1, 5'b0); check_output("b2b_0", 32'h0);
    apply_stimulus(12'h300, OP_RW, 1'b1, 1'b1, 32'h2, 5'b0); check_output("b2b_1", 32'h1);
    apply_stimulus(12'h300, OP_RS, 1'b1, 1'b0, 32'h4, 5'b0); check_output("b2b_2", 32'h2);
    read_csr(12'h300, 5'b0); check_output("b2b_3", 32'h6);

    apply_stimulus(12'h340, OP_RW, 1'b1, 1'b0, 32'hDEADBEEF, 5'b0); check_output("mscratch_old", 32'h0);
    apply_stimulus(12'h340, OP_RS, 1'b1, 1'b1, 32'h0000000F, 5'b0); check_output("mscratch_fwd", 32'hDEADBEEF);
    read_csr(12'h340, 5'b0); check_output("mscratch_fwd2", 32'hDEADBEEF);
    idle(2);
    read_csr(12'h340, 5'b0); check_output("mscratch_file", 32'hDEADBEEF);

    apply_stimulus(12'h304, OP_RW, 1'b1, 1'b0, 32'hFFFFFFFF, 5'b0); check_output("mie_old", 32'h0);
    apply_stimulus(12'h304, OP_RC, 1'b1, 1'b1, 32'h5, 5'b0); check_output("mie_fwd", 32'hFFFFFFFF);
    idle(2);
    read_csr(12'h304, 5'b0); check_output("mie_rc", 32'hFFFFFFFA);

    apply_stimulus(12'h305, OP_RW, 1'b1, 1'b0, 32'h1003, 5'b0); check_output("mtvec_old", 32'h0);
    read_csr(12'h305, 5'b0); check_output("mtvec_fwd", 32'h1000);
    idle(2);
    read_csr(12'h305, 5'b0); check_output("mtvec_file", 32'h1000);

    apply_stimulus(12'h343, OP_RW, 1'b1, 1'b0, 32'h11, 5'b0); check_output("mtval_old", 32'h0);
    idle(1);
    read_csr(12'h343, 5'b0); check_output("mtval_wb_fwd", 32'h11);
    apply_stimulus(12'h343, OP_RW, 1'b1, 1'b1, 32'h55, 5'b0); check_output("mtval_prev", 32'h11);
    read_csr(12'h343, 5'b00010); check_output("mtval_mem_fwd", 32'h55);
    read_csr(12'h343, 5'b0); check_output("mtval_flushW", 32'h11);
    read_csr(12'h343, 5'b0); check_output("mtval_flushW2", 32'h11);

    apply_stimulus(12'h341, OP_RW, 1'b1, 1'b0, 32'h1234, 5'b01000); check_output("mepc_old", 32'h0);
    read_csr(12'h341, 5'b0); check_output("mepc_flushM", 32'h0);
    idle(1);
    read_csr(12'h341, 5'b0); check_output("mepc_flushM2", 32'h0);

    apply_stimulus(12'h342, OP_RW, 1'b1, 1'b0, 32'h7, 5'b0); check_output("mcause_old", 32'h0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      read_csr(12'h342, 5'b00101); check_output("mcause_bubbleW", 32'h7);
    end
    read_csr(12'h342, 5'b00001); check_output("mcause_release", 32'h7);
    read_csr(12'h342, 5'b0); check_output("mcause_file", 32'h7);

    apply_stimulus(12'h7C0, OP_RW, 1'b1, 1'b0, 32'hFFFF, 5'b0); check_output("unimpl_old", 32'h0);
    read_csr(12'h7C0, 5'b0); check_output("unimpl_fwd", 32'h0);
    idle(1);
    read_csr(12'h7C0, 5'b0); check_output("unimpl_file", 32'h0);

    apply_stimulus(12'h344, OP_NONE, 1'b1, 1'b0, 32'h1234, 5'b0); check_output("mip_old", 32'h0);
    read_csr(12'h344, 5'b0); check_output("op00_fwd", 32'h0);
    idle(2);
    read_csr(12'h344, 5'b0); check_output("op00_file", 32'h0);

    apply_stimulus(12'hB00, OP_RW, 1'b1, 1'b0, 32'hFFFFFFFF, 5'b0);
    apply_stimulus(12'hB80, OP_RW, 1'b1, 1'b0, 32'h0, 5'b0);
    idle(1);
`ifdef CSR_COUNTERS_EN
    read_csr(12'hB00, 5'b0); check_output("mcycle_written", 32'hFFFFFFFF);
    read_csr(12'hB00, 5'b0); check_output("mcycle_held", 32'hFFFFFFFF);
    read_csr(12'hB00, 5'b0); check_output("mcycle_wrap", 32'h0);
    read_csr(12'hB80, 5'b0); check_output("mcycleh_carry", 32'h1);
`else
    read_csr(12'hB00, 5'b0); check_output("mcycle_drop", 32'h0);
    read_csr(12'hB80, 5'b0); check_output("mcycleh_drop", 32'h0);
`endif

    apply_stimulus(12'hB02, OP_RW, 1'b1, 1'b0, 32'hFFFFFFFE, 5'b00001);
    for (int i = 0; i < 4; i++) read_csr(12'hB02, 5'b00001);
    for (int i = 0; i < 3; i++) read_csr(12'hB82, 5'b00001);

    apply_stimulus(12'h300, OP_RW, 1'b1, 1'b0, 32'h0000A5A5, 5'b0);
    apply_stimulus(12'h300, OP_RS, 1'b1, 1'b1, 32'h00000F0F, 5'b10000);
    apply_stimulus(12'h300, OP_RS, 1'b1, 1'b1, 32'h00000F0F, 5'b0);
    apply_stimulus(12'h300, OP_RC, 1'b1, 1'b0, 32'h00000005, 5'b0);
    apply_stimulus(12'h300, OP_RS, 1'b0, 1'b0, 32'hFFFFFFFF, 5'b0); check_output("mstatus_mix", 32'h0000AFAA);
    apply_stimulus(12'h341, OP_RS, 1'b1, 1'b0, 32'h10, 5'b11000);
    apply_stimulus(12'h341, OP_RS, 1'b1, 1'b0, 32'h10, 5'b0);
    apply_stimulus(12'h343, OP_RC, 1'b1, 1'b1, 32'h1, 5'b00001);
    idle(3);
    read_csr(12'h300, 5'b0); check_output("mstatus_final", 32'h0000AFAA);
    read_csr(12'h341, 5'b0); check_output("mepc_final", 32'h10);
    read_csr(12'h343, 5'b0); check_output("mtval_final", 32'h10);

    idle(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file_wb.md
# csr_file_wb

CSR execution and commit unit, the consumer of the ID-EX CSR pipeline signals. In EX it reads the addressed CSR and computes the read-modify-write result; it carries the pending write through private MEM and WB pipeline registers and commits it at the end of WB. Forwarding keeps back-to-back CSR instructions coherent. Optional machine counters (mcycle/minstret) live here.

## Interface
Parameters:
- none; the CSR map is fixed.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- bubbleM, flushM  in  1 each  MEM-stage stall / flush
- bubbleW, flushW  in  1 each  WB-stage stall / flush
- CSR_addr_EX  in  12  CSR address
- CSR_zimm_EX  in  32  zero-extended immediate
- CSR_zimm_or_reg_EX  in  1  1 = source is zimm, 0 = source is rs1_data_EX
- CSR_write_en_EX  in  1  instruction writes its CSR
- CSR_op_EX  in  2  01 RW, 10 RS, 11 RC, 00 no CSR op
- rs1_data_EX  in  32  forwarded rs1 value
- instr_retire_W  in  1  one instruction retires this cycle
- CSR_data_EX  out  32  old CSR value, destined for rd

## Operation
- Implemented CSRs, all 32-bit RW: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344. mtvec[1:0] hard-wired 0 (write ignored, read 0).
- Unimplemented address: read 0, write dropped.
- src = CSR_zimm_or_reg_EX ? CSR_zimm_EX : rs1_data_EX. old = forwarded read value.
- new: RW -> src; RS -> old | src; RC -> old & ~src; op 00 -> no write regardless of CSR_write_en_EX.
- Read forwarding, highest priority first: MEM-stage pending write with same address and valid write; then WB-stage pending write; then CSR file.
- EX->MEM register {addr, wdata, we}: holds when bubbleM; loads we=0 when flushM (flush wins only when not bubbled); else loads EX values.
- MEM->WB register: same rules with bubbleW/flushW.
- Commit: at rising edge when WB we=1 and bubbleW=0, CSR file[addr] <= wdata.

## Timing
- Reset (rst_n=0, immediately): all CSRs, counters, MEM/WB pipeline registers 0; CSR_data_EX then reads 0 for every address.
- CSR_data_EX combinational from EX inputs and state; zero-cycle latency.
- Write visible to a dependent instruction in the next cycle via forwarding; visible in the file 2 edges after leaving EX (no stalls).
- Back-to-back writes to same CSR in EX, MEM, WB: EX sees MEM's value.
- Reset asserted mid-operation: pending MEM/WB writes discarded, never committed.
- Flush of MEM or WB kills only that stage's write; forwarding from a flushed slot never occurs.

## Configuration
- CSR_COUNTERS_EN defined: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82 implemented as two 64-bit counters. mcycle +1 every cycle out of reset; minstret +1 each cycle instr_retire_W=1; both wrap 2^64-1 -> 0 with carry into high word. A committed write to either half wins over the increment that cycle (increment dropped); the other half is unchanged. Counter reads are forwarded like other CSRs.
- Not defined: these addresses behave as unimplemented (read 0, write dropped); no counter logic synthesized.

## Test plan
- Reset then read 0x300, 0x305, 0xB00 -> all 0; release reset, with counters enabled, mcycle read after 10 cycles = 10.
- CSRRW mscratch src=0xDEADBEEF, next cycle CSRRS mscratch src=0x0000000F -> second CSR_data_EX=0xDEADBEEF (MEM forward), committed mscratch=0xDEADBEEF.
- CSRRC mie old=0xFFFFFFFF zimm=0x5 -> file becomes 0xFFFFFFFA; mtvec write 0x1003 -> reads 0x1000.
- CSRRW mepc=0x1234 with flushM asserted the cycle it enters MEM -> mepc stays 0, following read returns 0.
- Counters: write mcycle=0xFFFFFFFF, mcycleh=0 -> after commit one increment gives mcycle=0, mcycleh=1; write during increment -> written value held, no +1.
- bubbleW held 3 cycles with pending WB write to mcause=7 -> no commit until bubbleW drops; EX read of mcause meanwhile returns 7 via forwarding.
